// File: rtl/bram_frame_buffer_pkg.sv
// Shared types and constants for the single-frame capture/replay buffer.
package bram_frame_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Edges from READ entry to the first valid pixel on oData:
  // RAM address register, RAM output register, oData register.
  localparam int RD_LAT = 3;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: synchronous write port and a two-register read port
// (address register + output register), shaped for block-RAM inference.
module bram_sdp #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 307200,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr_q;
  logic [WIDTH-1:0] rdata_q;

  // Storage has no reset so it maps onto the RAM primitive.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // The held address keeps re-reading the last location once reads stop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      if (re_i) begin
        raddr_q <= raddr_i;
      end
      rdata_q <= mem[raddr_q];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_frame_buffer.sv
// Captures one frame of pixels into block RAM after reset, then streams it
// back out once in the same linear order and holds the last pixel.
module bram_frame_buffer
  import bram_frame_buffer_pkg::*;
#(
  parameter int RAM_WIDTH   = 8,
  parameter int RAM_DEPTH   = 307200,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int TILE_WIDTH  = 16,
  parameter int TILE_HEIGHT = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [RAM_WIDTH-1:0] iData,
  output logic [RAM_WIDTH-1:0] oData
);

  localparam int            AW   = $clog2(RAM_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(RAM_DEPTH - 1);

  if (RAM_DEPTH < 2) begin : g_chk_depth
    $error("bram_frame_buffer: RAM_DEPTH must be at least 2");
  end
  if ((IMG_WIDTH % TILE_WIDTH) != 0) begin : g_chk_tile_w
    $error("bram_frame_buffer: IMG_WIDTH must be a multiple of TILE_WIDTH");
  end
  if ((IMG_HEIGHT % TILE_HEIGHT) != 0) begin : g_chk_tile_h
    $error("bram_frame_buffer: IMG_HEIGHT must be a multiple of TILE_HEIGHT");
  end
  if (RAM_DEPTH > IMG_WIDTH * IMG_HEIGHT) begin : g_chk_frame
    $error("bram_frame_buffer: RAM_DEPTH exceeds IMG_WIDTH*IMG_HEIGHT");
  end

  state_e                 state_q, state_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic [RD_LAT-2:0]      vld_q;
  logic [RAM_WIDTH-1:0]   odata_q;
  logic                   ram_we;
  logic                   ram_re;
  logic [RAM_WIDTH-1:0]   ram_rdata;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (wr_addr_q == LAST) begin
          wr_addr_d = '0;
          rd_addr_d = '0;
          state_d   = READ;
        end else begin
          wr_addr_d = wr_addr_q + 1'b1;
        end
      end
      READ: begin
        ram_re = 1'b1;
        if (rd_addr_q == LAST) begin
          rd_addr_d = '0;
          state_d   = DONE;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // vld_q tracks issued reads through the RAM so oData only loads real pixels.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      vld_q     <= '0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= {vld_q, ram_re};
      if (vld_q[RD_LAT-2]) begin
        odata_q <= ram_rdata;
      end
    end
  end

  bram_sdp #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk_i   (iClk),
    .rst_ni  (iRst),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (iData),
    .re_i    (ram_re),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  assign oData = odata_q;

endmodule

// File: tb/tb_bram_frame_buffer.sv
// Scoreboard bench: stimulus schedules expected oData values per cycle,
// a negedge monitor pops and compares them.
module tb_bram_frame_buffer;

  localparam int W = 8;
  localparam int N = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din   = '0;
  logic [W-1:0] dout;

  always #5 clk = ~clk;

  bram_frame_buffer #(
    .RAM_WIDTH   (W),
    .RAM_DEPTH   (N),
    .IMG_WIDTH   (640),
    .IMG_HEIGHT  (480),
    .TILE_WIDTH  (16),
    .TILE_HEIGHT (16)
  ) dut (
    .iClk  (clk),
    .iRst  (rst_n),
    .iData (din),
    .oData (dout)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry scheduled for the edge just past.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: check for cycle %0d missed, now cycle %0d", e.name, e.cyc, cyc);
      end else if (dout !== e.val) begin
        n_err++;
        $display("FAIL %s: cycle %0d oData=%h expected %h", e.name, cyc, dout, e.val);
      end else begin
        $display("ok   %s: cycle %0d oData=%h", e.name, cyc, dout);
      end
    end
  end

  task automatic push(input int c, input logic [W-1:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      din   = 8'hFF;
      push(cyc + 1, 8'h00, "rst_zero");
    end
  endtask

  // Releases reset and drives a full frame; e0 is the absolute cycle of edge 0.
  task automatic fill(input logic [W-1:0] base, output int e0);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 8'hFF;
    e0    = cyc + 1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      din = base + 8'(k);
    end
    @(negedge clk);
    din = 8'hAA;
  endtask

  task automatic expect_frame(input int e0, input logic [W-1:0] base, input int hold);
    for (int k = 0; k < N; k++) begin
      push(e0 + N + 3 + k, base + 8'(k), "readback");
    end
    for (int j = 1; j <= hold; j++) begin
      push(e0 + 2 * N + 2 + j, base + 8'(N - 1), "done_hold");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected values never checked", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int e0;
    int target;

    // Long reset hold with iData=FF, then a linear fill and readback plus DONE hold.
    hold_reset(10);
    fill(8'h10, e0);
    expect_frame(e0, 8'h10, 8);
    drain();

    // Reset asserted at edge 8 of a fill, then a clean refill.
    hold_reset(2);
    @(negedge clk);
    rst_n = 1'b1;
    e0    = cyc + 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      din = 8'h30 + 8'(k);
    end
    hold_reset(3);
    fill(8'h80, e0);
    expect_frame(e0, 8'h80, 4);
    drain();

    // Reset during READ: oData clears on the next edge, then a new frame.
    hold_reset(2);
    fill(8'h40, e0);
    for (int k = 0; k < 4; k++) begin
      push(e0 + N + 3 + k, 8'h40 + 8'(k), "readback_pre_abort");
    end
    target = e0 + N + 6;
    for (int i = 0; i < 100 && cyc < target; i++) begin
      @(negedge clk);
    end
    rst_n = 1'b0;
    push(cyc + 1, 8'h00, "rd_abort_zero");
    hold_reset(2);
    fill(8'hE0, e0);
    expect_frame(e0, 8'hE0, 4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
